// File: rtl/keypad_num_entry_pkg.sv
// keypad_num_entry_pkg
//   Shared definitions for the keypad number-entry path:
//   - scanner FSM state type
//   - key code constants for the command keys
//   - matrix position to key code table and row priority helper
package keypad_num_entry_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } scan_state_t;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_LAST_DIGIT = 4'd9;

    // Matrix layout (row r, col c):
    //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
    function automatic logic [3:0] key_decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = '0;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Index of the lowest active-low row; only meaningful when row != 4'hF.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_num_entry_if.sv
// keypad_num_entry_if
//   Bundles the keypad matrix pins and the number-entry results.
//   row         matrix rows, active-low (driven by the keypad side)
//   col         matrix columns, active-low, at most one low
//   key_code    last decoded key
//   key_valid   1-clk pulse per debounced press
//   entry       value being typed
//   digit_count digits currently in entry
//   num         last committed value
//   num_valid   1-clk pulse when num updates
//   overflow    sticky digit-rejected flag
//   master: the keypad_num_entry block; slave: the keypad / consumer side.
interface keypad_num_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic [15:0] num;
    logic        num_valid;
    logic        overflow;

    modport master (
        input  row,
        output col, key_code, key_valid, entry, digit_count, num, num_valid, overflow
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, entry, digit_count, num, num_valid, overflow
    );
endinterface

// File: rtl/keypad_num_entry_scanner.sv
// keypad_num_entry_scanner
//   Scans a 4x4 active-low key matrix one column at a time, debounces and
//   decodes key presses.
//   clk       system clock
//   rst       synchronous, active-low reset
//   row       matrix rows (asynchronous, active-low)
//   col       matrix columns, active-low, one low at a time
//   key_code  last decoded key
//   key_valid 1-clk pulse per debounced press
module keypad_num_entry_scanner
    import keypad_num_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV_BITS  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_BITS-1:0] div_q;
    logic                     tick;

    logic [3:0] row_meta;
    logic [3:0] row_sync;

    scan_state_t      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    assign tick = &div_q;

    // cnt counts identical press samples in DEBOUNCE and consecutive
    // all-released samples in HELD.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        fire      = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_sync == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = lowest_low_row(row_sync);
                        pat_d     = row_sync;
                        cnt_d     = CNT_W'(1);
                        state_d   = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_sync == pat_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_DONE) begin
                            fire    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (row_sync == 4'hF) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_DONE) begin
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= '0;
            row_meta  <= '1;
            row_sync  <= '1;
            state_q   <= ST_SCAN;
            col_idx_q <= '0;
            row_idx_q <= '0;
            pat_q     <= '1;
            cnt_q     <= '0;
            col       <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            div_q     <= div_q + SCAN_DIV_BITS'(1);
            row_meta  <= row;
            row_sync  <= row_meta;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            col       <= ~(4'b0001 << col_idx_d);
            key_valid <= fire;
            if (fire) begin
                key_code <= key_decode(row_idx_q, col_idx_q);
            end
        end
    end

endmodule

// File: rtl/keypad_num_entry.sv
// keypad_num_entry
//   Keypad number entry: scans/debounces a 4x4 matrix and accumulates decimal
//   digits into a 16-bit value, committed with the enter key.
//   clk  system clock
//   rst  synchronous, active-low reset
//   bus  master side of keypad_num_entry_if:
//        row in, col out, key_code/key_valid out, entry/digit_count out,
//        num/num_valid out, overflow out
//   Keys: 0-9 digits, E backspace, F enter, A clear, B/C/D reported only.
module keypad_num_entry
    import keypad_num_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV_BITS  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned MAX_DIGITS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_num_entry_if.master   bus
);

    logic [3:0] key_code;
    logic       key_valid;

    keypad_num_entry_scanner #(
        .SCAN_DIV_BITS  (SCAN_DIV_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .row       (bus.row),
        .col       (bus.col),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] num_q, num_d;
    logic        num_valid_d, num_valid_q;
    logic        ovf_q, ovf_d;
    logic [19:0] appended;

    // Wide enough that entry*10+9 never wraps, so the 16-bit limit test is exact.
    assign appended = 20'(entry_q) * 20'd10 + 20'(key_code);

    always_comb begin
        entry_d     = entry_q;
        count_d     = count_q;
        num_d       = num_q;
        num_valid_d = 1'b0;
        ovf_d       = ovf_q;
        if (key_valid) begin
            if (key_code <= KEY_LAST_DIGIT) begin
                if ((32'(count_q) < MAX_DIGITS) && (appended <= 20'd65535)) begin
                    entry_d = appended[15:0];
                    count_d = count_q + 3'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                case (key_code)
                    KEY_BKSP: begin
                        if (count_q != 3'd0) begin
                            entry_d = entry_q / 16'd10;
                            count_d = count_q - 3'd1;
                        end
                    end
                    KEY_ENTER: begin
                        num_d       = entry_q;
                        num_valid_d = 1'b1;
                        entry_d     = '0;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                    end
                    KEY_CLR: begin
                        entry_d = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q     <= '0;
            count_q     <= '0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            count_q     <= count_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.key_code    = key_code;
    assign bus.key_valid   = key_valid;
    assign bus.entry       = entry_q;
    assign bus.digit_count = count_q;
    assign bus.num         = num_q;
    assign bus.num_valid   = num_valid_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_num_entry.sv
module tb_keypad_num_entry;

    logic clk;
    logic rst;
    logic [15:0] keys;
    logic [3:0]  row_v;

    keypad_num_entry_if bus ();

    keypad_num_entry #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (4),
        .MAX_DIGITS     (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key model: a pressed key at (r,c) pulls row r low while column c is low.
    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !bus.col[c]) row_v[r] = 1'b0;
            end
        end
        bus.row = row_v;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor
    int         kv_cnt = 0;
    int         nv_cnt = 0;
    logic [3:0] last_code = '0;
    always @(negedge clk) begin
        if (bus.key_valid) begin
            kv_cnt++;
            last_code = bus.key_code;
        end
        if (bus.num_valid) nv_cnt++;
    end

    // Reference model of the number entry, in plain integers
    int m_entry = 0;
    int m_cnt   = 0;
    int m_ovf   = 0;
    int m_num   = 0;

    function automatic void model_reset();
        m_entry = 0; m_cnt = 0; m_ovf = 0; m_num = 0;
    endfunction

    // Returns number of num_valid pulses this key should produce.
    function automatic int model_key(input int code);
        int nv;
        nv = 0;
        if (code <= 9) begin
            if (m_cnt < 5 && m_entry * 10 + code <= 65535) begin
                m_entry = m_entry * 10 + code;
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end else if (code == 14) begin
            if (m_cnt > 0) begin
                m_entry = m_entry / 10;
                m_cnt--;
            end
        end else if (code == 15) begin
            m_num = m_entry; m_entry = 0; m_cnt = 0; m_ovf = 0; nv = 1;
        end else if (code == 10) begin
            m_entry = 0; m_cnt = 0; m_ovf = 0;
        end
        return nv;
    endfunction

    function automatic int code_of(input int r, input int c);
        int k;
        k = 0;
        case (r * 4 + c)
            0: k = 1;   1: k = 2;   2: k = 3;   3: k = 10;
            4: k = 4;   5: k = 5;   6: k = 6;   7: k = 11;
            8: k = 7;   9: k = 8;  10: k = 9;  11: k = 12;
            12: k = 14; 13: k = 0; 14: k = 15; default: k = 13;
        endcase
        return k;
    endfunction

    function automatic logic [15:0] kmask(input int r, input int c);
        logic [15:0] m;
        m = 16'd1;
        return m << (r * 4 + c);
    endfunction

    function automatic logic [15:0] digit_mask(input int d);
        logic [15:0] m;
        case (d)
            0: m = kmask(3, 1); 1: m = kmask(0, 0); 2: m = kmask(0, 1);
            3: m = kmask(0, 2); 4: m = kmask(1, 0); 5: m = kmask(1, 1);
            6: m = kmask(1, 2); 7: m = kmask(2, 0); 8: m = kmask(2, 1);
            default: m = kmask(2, 2);
        endcase
        return m;
    endfunction

    task automatic press(input logic [15:0] mask, input int exp_code, input int hold_ticks);
        int kv0, nv0, n, exp_nv;
        kv0 = kv_cnt;
        nv0 = nv_cnt;
        keys = mask;
        n = 0;
        while (kv_cnt == kv0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("key_seen", kv_cnt - kv0, 1);
        repeat (hold_ticks * 4) @(negedge clk);
        keys = '0;
        repeat (48) @(negedge clk);
        #1;
        check("key_once", kv_cnt - kv0, 1);
        check("key_code", last_code, exp_code);
        exp_nv = model_key(exp_code);
        check("entry", bus.entry, m_entry);
        check("digit_count", bus.digit_count, m_cnt);
        check("overflow", bus.overflow, m_ovf);
        check("num", bus.num, m_num);
        check("num_valid_pulses", nv_cnt - nv0, exp_nv);
    endtask

    task automatic press_digit(input int d);
        press(digit_mask(d), d, 8);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n;
        n = 0;
        while (bus.col !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", bus.col, want);
    endtask

    logic [3:0] col_seq [5];
    logic [3:0] prev;

    initial begin
        int n, kv0, r, c;
        col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110; col_seq[4] = 4'b1101;
        keys = '0;
        rst  = 1'b0;

        // 1. reset state and column stepping
        repeat (5) @(negedge clk);
        check("rst_col", bus.col, 4'hF);
        check("rst_num", bus.num, 0);
        check("rst_num_valid", bus.num_valid, 0);
        check("rst_key_valid", bus.key_valid, 0);
        check("rst_key_code", bus.key_code, 0);
        check("rst_entry", bus.entry, 0);
        check("rst_count", bus.digit_count, 0);
        check("rst_overflow", bus.overflow, 0);
        rst = 1'b1;
        wait_col(4'b1110);
        prev = bus.col;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.col === prev && n < 10);
            check("col_step", bus.col, col_seq[i]);
            if (i > 0) check("col_period", n, 4);
            prev = bus.col;
        end
        model_reset();

        // 2. 1,2,3,# -> num=123
        press_digit(1);
        press_digit(2);
        press_digit(3);
        press(kmask(3, 2), 15, 8);

        // 3. bounce on '5' gives nothing, long hold gives one event
        wait_col(4'b1101);
        kv0 = kv_cnt;
        keys = kmask(1, 1);
        repeat (8) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("bounce_no_key", kv_cnt - kv0, 0);
        press(kmask(1, 1), 5, 40);

        // 4. limits
        press(kmask(0, 3), 10, 2);
        press_digit(6); press_digit(5); press_digit(5); press_digit(3); press_digit(5);
        press_digit(0);
        press(kmask(0, 3), 10, 2);
        press_digit(6); press_digit(5); press_digit(5); press_digit(3); press_digit(6);
        press(kmask(0, 3), 10, 2);

        // 5. backspace and multi-key
        press_digit(4); press_digit(7);
        press(kmask(3, 0), 14, 2);
        press(kmask(3, 0), 14, 2);
        press(kmask(3, 0), 14, 2);
        press(kmask(0, 0) | kmask(2, 0), 1, 4);
        press(kmask(0, 3), 10, 2);

        // 6. reset in the middle of debouncing '9'
        press_digit(1); press_digit(2);
        wait_col(4'b1011);
        kv0 = kv_cnt;
        keys = kmask(2, 2);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        keys = '0;
        repeat (2) @(negedge clk);
        check("mid_rst_entry", bus.entry, 0);
        check("mid_rst_count", bus.digit_count, 0);
        check("mid_rst_num", bus.num, 0);
        rst = 1'b1;
        @(negedge clk);
        check("resume_col0", bus.col, 4'b1110);
        repeat (40) @(negedge clk);
        check("mid_rst_no_key", kv_cnt - kv0, 0);
        model_reset();

        // Randomized key sequence
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            press(kmask(r, c), code_of(r, c), $urandom_range(0, 10));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
